// File: rtl/imem_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | imem_pkg : shared states and constants for the imem_responder fetch path  |
// | Rev 1.0  : initial release (PF state present only with IMEM_PREFETCH_EN)  |
// +--------------------------------------------------------------------------+
package imem_pkg;

   localparam int          TIMEOUT_CYC_DEFAULT = 255;
   localparam int          CNT_W               = 8;
   localparam logic [31:0] NOP_INSTR           = 32'h0000_0013;
   localparam logic [31:0] LAST_WORD           = 32'hFFFF_FFFC;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      DRAIN
`ifdef IMEM_PREFETCH_EN
      , PF
`endif
   } state_e;

   function automatic logic is_aligned(input logic [31:0] addr);
      return (addr[1:0] == 2'b00);
   endfunction

endpackage : imem_pkg
`default_nettype wire

// File: rtl/imem_pf_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | imem_pf_buffer : one-entry prefetch buffer (tag, data, valid)            |
// | Rev 1.0  : initial release; used only when IMEM_PREFETCH_EN is defined   |
// +--------------------------------------------------------------------------+
module imem_pf_buffer
   import imem_pkg::*;
(
   input  logic        stage_clk,
   input  logic        reset_n,
   input  logic        wr_en,
   input  logic [31:0] wr_tag,
   input  logic [31:0] wr_data,
   input  logic        invalidate,
   input  logic [31:0] lookup_addr,
   output logic        hit,
   output logic [31:0] rd_data
);

   logic [31:0] tag_q,   tag_d;
   logic [31:0] data_q,  data_d;
   logic        valid_q, valid_d;

   // Invalidate wins over a same-cycle write so a redirect never leaves stale data.
   always_comb begin
      tag_d   = tag_q;
      data_d  = data_q;
      valid_d = valid_q;
      if (invalidate) begin
         valid_d = 1'b0;
      end else if (wr_en) begin
         tag_d   = wr_tag;
         data_d  = wr_data;
         valid_d = 1'b1;
      end
   end

   always_ff @(posedge stage_clk or negedge reset_n) begin
      if (!reset_n) begin
         tag_q   <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         tag_q   <= tag_d;
         data_q  <= data_d;
         valid_q <= valid_d;
      end
   end

   assign hit     = valid_q && (tag_q == lookup_addr);
   assign rd_data = data_q;

endmodule : imem_pf_buffer
`default_nettype wire

// File: rtl/imem_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | imem_responder : instruction-fetch responder with timeout and flush      |
// | Rev 1.0  : initial release; IMEM_PREFETCH_EN adds next-line prefetch     |
// +--------------------------------------------------------------------------+
module imem_responder
   import imem_pkg::*;
#(
   parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
   input  logic        stage_clk,
   input  logic        reset_n,
   input  logic        fetch_req,
   input  logic [31:0] fetch_pc,
   input  logic        flush,
   output logic [31:0] instr_out,
   output logic        instr_valid,
   output logic        stall,
   output logic        fault,
   output logic        mem_rd,
   output logic [31:0] mem_addr,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack
);

   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);

   state_e             state_q,       state_d;
   logic [CNT_W-1:0]   cnt_q,         cnt_d;
   logic               mem_rd_q,      mem_rd_d;
   logic [31:0]        mem_addr_q,    mem_addr_d;
   logic [31:0]        instr_out_q,   instr_out_d;
   logic               instr_valid_q, instr_valid_d;
   logic               fault_q,       fault_d;

   logic               timeout;
   logic               pf_hit;
   logic [31:0]        pf_rdata;

`ifdef IMEM_PREFETCH_EN
   logic               pf_wr;

   imem_pf_buffer u_pf_buffer (
      .stage_clk   (stage_clk),
      .reset_n     (reset_n),
      .wr_en       (pf_wr),
      .wr_tag      (mem_addr_q),
      .wr_data     (mem_rdata),
      .invalidate  (flush),
      .lookup_addr (fetch_pc),
      .hit         (pf_hit),
      .rd_data     (pf_rdata)
   );
`else
   assign pf_hit   = 1'b0;
   assign pf_rdata = '0;
`endif

   assign timeout = (cnt_q == TMO_LAST);

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      mem_rd_d      = mem_rd_q;
      mem_addr_d    = mem_addr_q;
      instr_out_d   = instr_out_q;
      instr_valid_d = 1'b0;
      fault_d       = 1'b0;
`ifdef IMEM_PREFETCH_EN
      pf_wr         = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            mem_rd_d = 1'b0;
            cnt_d    = '0;
            if (fetch_req && !flush) begin
               if (!is_aligned(fetch_pc)) begin
                  instr_valid_d = 1'b1;
                  fault_d       = 1'b1;
                  instr_out_d   = NOP_INSTR;
               end else if (pf_hit) begin
                  instr_valid_d = 1'b1;
                  instr_out_d   = pf_rdata;
               end else begin
                  state_d    = REQ;
                  mem_rd_d   = 1'b1;
                  mem_addr_d = fetch_pc;
               end
            end
         end
         REQ: begin
            cnt_d = cnt_q + 1'b1;
            if (flush) begin
               // Flush beats a same-cycle ack: the returned word is dropped.
               if (mem_ack || timeout) begin
                  state_d  = IDLE;
                  mem_rd_d = 1'b0;
               end else begin
                  state_d = DRAIN;
               end
            end else if (mem_ack) begin
               instr_valid_d = 1'b1;
               instr_out_d   = mem_rdata;
`ifdef IMEM_PREFETCH_EN
               if (mem_addr_q != LAST_WORD) begin
                  state_d    = PF;
                  mem_addr_d = mem_addr_q + 32'd4;
                  cnt_d      = '0;
               end else begin
                  state_d  = IDLE;
                  mem_rd_d = 1'b0;
               end
`else
               state_d  = IDLE;
               mem_rd_d = 1'b0;
`endif
            end else if (timeout) begin
               state_d       = IDLE;
               mem_rd_d      = 1'b0;
               instr_valid_d = 1'b1;
               fault_d       = 1'b1;
               instr_out_d   = NOP_INSTR;
            end
         end
         DRAIN: begin
            cnt_d = cnt_q + 1'b1;
            if (mem_ack || timeout) begin
               state_d  = IDLE;
               mem_rd_d = 1'b0;
            end
         end
`ifdef IMEM_PREFETCH_EN
         PF: begin
            cnt_d = cnt_q + 1'b1;
            if (flush) begin
               if (mem_ack || timeout) begin
                  state_d  = IDLE;
                  mem_rd_d = 1'b0;
               end else begin
                  state_d = DRAIN;
               end
            end else if (mem_ack) begin
               pf_wr    = 1'b1;
               state_d  = IDLE;
               mem_rd_d = 1'b0;
            end else if (timeout) begin
               state_d  = IDLE;
               mem_rd_d = 1'b0;
            end
         end
`endif
         default: begin
            state_d  = IDLE;
            mem_rd_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge stage_clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         mem_rd_q      <= 1'b0;
         mem_addr_q    <= '0;
         instr_out_q   <= '0;
         instr_valid_q <= 1'b0;
         fault_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         mem_rd_q      <= mem_rd_d;
         mem_addr_q    <= mem_addr_d;
         instr_out_q   <= instr_out_d;
         instr_valid_q <= instr_valid_d;
         fault_q       <= fault_d;
      end
   end

   assign stall       = (state_q != IDLE);
   assign instr_out   = instr_out_q;
   assign instr_valid = instr_valid_q;
   assign fault       = fault_q;
   assign mem_rd      = mem_rd_q;
   assign mem_addr    = mem_addr_q;

endmodule : imem_responder
`default_nettype wire

// File: tb/tb_imem_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_imem_responder : directed self-checking bench for imem_responder      |
// | Rev 1.0  : initial release; follows IMEM_PREFETCH_EN when it is defined  |
// +--------------------------------------------------------------------------+
module tb_imem_responder;

   logic        stage_clk = 1'b0;
   logic        reset_n;
   logic        fetch_req;
   logic [31:0] fetch_pc;
   logic        flush;
   logic [31:0] instr_out;
   logic        instr_valid;
   logic        stall;
   logic        fault;
   logic        mem_rd;
   logic [31:0] mem_addr;
   logic [31:0] mem_rdata;
   logic        mem_ack;

   int checks   = 0;
   int failures = 0;
   int rd_cycles;

   imem_responder #(.TIMEOUT_CYC(255)) dut (
      .stage_clk   (stage_clk),
      .reset_n     (reset_n),
      .fetch_req   (fetch_req),
      .fetch_pc    (fetch_pc),
      .flush       (flush),
      .instr_out   (instr_out),
      .instr_valid (instr_valid),
      .stall       (stall),
      .fault       (fault),
      .mem_rd      (mem_rd),
      .mem_addr    (mem_addr),
      .mem_rdata   (mem_rdata),
      .mem_ack     (mem_ack)
   );

   always #5 stage_clk = ~stage_clk;

   task automatic tick();
      @(posedge stage_clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_out"},   instr_out,   32'h0);
      chk({tag, "_valid"}, instr_valid, 32'h0);
      chk({tag, "_stall"}, stall,       32'h0);
      chk({tag, "_fault"}, fault,       32'h0);
      chk({tag, "_rd"},    mem_rd,      32'h0);
      chk({tag, "_addr"},  mem_addr,    32'h0);
   endtask

`ifdef IMEM_PREFETCH_EN
   task automatic pf_complete(input logic [31:0] addr, input logic [31:0] data);
      chk("pf_rd",   mem_rd,   32'h1);
      chk("pf_addr", mem_addr, addr);
      mem_ack   = 1'b1;
      mem_rdata = data;
      tick();
      mem_ack   = 1'b0;
      chk("pf_done_rd",    mem_rd, 32'h0);
      chk("pf_done_stall", stall,  32'h0);
   endtask
`endif

   initial begin
      reset_n   = 1'b0;
      fetch_req = 1'b0;
      fetch_pc  = '0;
      flush     = 1'b0;
      mem_rdata = '0;
      mem_ack   = 1'b0;
      #2;
      chk_zero("reset");
      tick();
      tick();
      reset_n = 1'b1;

      // Aligned miss at 0x100, ack on the third REQ cycle.
      fetch_req = 1'b1;
      fetch_pc  = 32'h100;
      tick();
      fetch_req = 1'b0;
      chk("t1_rd",     mem_rd,      32'h1);
      chk("t1_addr",   mem_addr,    32'h100);
      chk("t1_stall1", stall,       32'h1);
      chk("t1_novalid", instr_valid, 32'h0);
      tick();
      chk("t1_stall2", stall,  32'h1);
      chk("t1_rd2",    mem_rd, 32'h1);
      tick();
      chk("t1_stall3", stall,    32'h1);
      chk("t1_addr3",  mem_addr, 32'h100);
      mem_ack   = 1'b1;
      mem_rdata = 32'hDEAD_BEEF;
      tick();
      mem_ack = 1'b0;
      chk("t1_valid", instr_valid, 32'h1);
      chk("t1_data",  instr_out,   32'hDEAD_BEEF);
      chk("t1_fault", fault,       32'h0);
`ifdef IMEM_PREFETCH_EN
      chk("t1_pf_stall", stall, 32'h1);
      pf_complete(32'h104, 32'h0104_0104);
`else
      chk("t1_stall_rel", stall,  32'h0);
      chk("t1_rd_drop",   mem_rd, 32'h0);
      tick();
`endif
      chk("t1_pulse", instr_valid, 32'h0);

      // Misaligned fetch: NOP with fault, no memory read.
      fetch_req = 1'b1;
      fetch_pc  = 32'h102;
      tick();
      fetch_req = 1'b0;
      chk("t2_valid", instr_valid, 32'h1);
      chk("t2_fault", fault,       32'h1);
      chk("t2_nop",   instr_out,   32'h0000_0013);
      chk("t2_rd",    mem_rd,      32'h0);
      chk("t2_stall", stall,       32'h0);
      tick();
      chk("t2_pulse", instr_valid, 32'h0);
      chk("t2_fault_pulse", fault, 32'h0);
      chk("t2_rd2",   mem_rd,      32'h0);

      // Miss at 0x200, flushed one cycle later, ack two cycles after that.
      fetch_req = 1'b1;
      fetch_pc  = 32'h200;
      tick();
      fetch_req = 1'b0;
      chk("t3_rd", mem_rd, 32'h1);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("t3_drain_stall", stall,       32'h1);
      chk("t3_drain_rd",    mem_rd,      32'h1);
      chk("t3_drain_addr",  mem_addr,    32'h200);
      chk("t3_drain_valid", instr_valid, 32'h0);
      tick();
      chk("t3_stall2", stall,       32'h1);
      chk("t3_valid2", instr_valid, 32'h0);
      mem_ack   = 1'b1;
      mem_rdata = 32'hCAFE_F00D;
      tick();
      mem_ack = 1'b0;
      chk("t3_idle_stall", stall,       32'h0);
      chk("t3_idle_rd",    mem_rd,      32'h0);
      chk("t3_discard",    instr_valid, 32'h0);
      tick();
      chk("t3_discard2", instr_valid, 32'h0);

      // Flush and ack in the same REQ cycle: data discarded, back to IDLE.
      fetch_req = 1'b1;
      fetch_pc  = 32'h240;
      tick();
      fetch_req = 1'b0;
      flush     = 1'b1;
      mem_ack   = 1'b1;
      mem_rdata = 32'h1234_5678;
      tick();
      flush   = 1'b0;
      mem_ack = 1'b0;
      chk("t4_valid", instr_valid, 32'h0);
      chk("t4_stall", stall,       32'h0);
      chk("t4_rd",    mem_rd,      32'h0);

      // Flush in IDLE suppresses a same-cycle request.
      fetch_req = 1'b1;
      fetch_pc  = 32'h280;
      flush     = 1'b1;
      tick();
      fetch_req = 1'b0;
      flush     = 1'b0;
      chk("t5_rd",    mem_rd,      32'h0);
      chk("t5_stall", stall,       32'h0);
      chk("t5_valid", instr_valid, 32'h0);

      // No ack: mem_rd must stay up for exactly 255 cycles, then fault.
      fetch_req = 1'b1;
      fetch_pc  = 32'h400;
      tick();
      fetch_req = 1'b0;
      rd_cycles = (mem_rd === 1'b1) ? 1 : 0;
      for (int i = 0; i < 300; i++) begin
         tick();
         if (mem_rd !== 1'b1) break;
         rd_cycles++;
      end
      chk("t6_rd_cycles", rd_cycles,   32'd255);
      chk("t6_rd_drop",   mem_rd,      32'h0);
      chk("t6_valid",     instr_valid, 32'h1);
      chk("t6_fault",     fault,       32'h1);
      chk("t6_nop",       instr_out,   32'h0000_0013);
      chk("t6_stall",     stall,       32'h0);
      tick();

      // 0x300 then 0x304: hit from the prefetch buffer when enabled, miss otherwise.
      fetch_req = 1'b1;
      fetch_pc  = 32'h300;
      tick();
      fetch_req = 1'b0;
      mem_ack   = 1'b1;
      mem_rdata = 32'h1111_0300;
      tick();
      mem_ack = 1'b0;
      chk("t7_valid", instr_valid, 32'h1);
      chk("t7_data",  instr_out,   32'h1111_0300);
`ifdef IMEM_PREFETCH_EN
      pf_complete(32'h304, 32'h2222_0304);
      fetch_req = 1'b1;
      fetch_pc  = 32'h304;
      tick();
      fetch_req = 1'b0;
      chk("t7_hit_valid", instr_valid, 32'h1);
      chk("t7_hit_data",  instr_out,   32'h2222_0304);
      chk("t7_hit_rd",    mem_rd,      32'h0);
`else
      chk("t7_no_pf", mem_rd, 32'h0);
      fetch_req = 1'b1;
      fetch_pc  = 32'h304;
      tick();
      fetch_req = 1'b0;
      chk("t7_miss_rd",   mem_rd,   32'h1);
      chk("t7_miss_addr", mem_addr, 32'h304);
      mem_ack   = 1'b1;
      mem_rdata = 32'h2222_0304;
      tick();
      mem_ack = 1'b0;
      chk("t7_miss_data", instr_out, 32'h2222_0304);
`endif
      tick();

      // Last word of the address space never triggers a prefetch.
      fetch_req = 1'b1;
      fetch_pc  = 32'hFFFF_FFFC;
      tick();
      fetch_req = 1'b0;
      chk("t8_addr", mem_addr, 32'hFFFF_FFFC);
      mem_ack   = 1'b1;
      mem_rdata = 32'hABCD_0001;
      tick();
      mem_ack = 1'b0;
      chk("t8_data",  instr_out, 32'hABCD_0001);
      chk("t8_no_pf", mem_rd,    32'h0);
      chk("t8_stall", stall,     32'h0);
      tick();

      // Reset mid-transaction, then a late ack that must be ignored.
      fetch_req = 1'b1;
      fetch_pc  = 32'h500;
      tick();
      fetch_req = 1'b0;
      chk("t9_rd", mem_rd, 32'h1);
      #2;
      reset_n = 1'b0;
      #1;
      chk_zero("t9_async");
      tick();
      reset_n   = 1'b1;
      mem_ack   = 1'b1;
      mem_rdata = 32'h5555_AAAA;
      tick();
      mem_ack = 1'b0;
      chk_zero("t9_late_ack");
      tick();
      chk("t9_valid_after", instr_valid, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_imem_responder
`default_nettype wire
